// File: rtl/loopback_smoke_bfm_core_if.sv
// loopback_smoke_bfm_core_if: init, invocation and response signals of the loopback BFM core
interface loopback_smoke_bfm_core_if #(
    parameter int ID_W   = 64,
    parameter int PRM_W  = 32,
    parameter int INST_W = 16,
    parameter int CNT_W  = 32
);
    logic              ep_present;
    logic              init_req;
    logic [INST_W-1:0] init_inst_id;
    logic              defined;
    logic              fatal_err;
    logic              req_valid;
    logic              req_ready;
    logic              req_blocking;
    logic [ID_W-1:0]   req_method_id;
    logic [INST_W-1:0] req_inst_id;
    logic [PRM_W-1:0]  req_param;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_has_retval;
    logic [PRM_W-1:0]  rsp_retval;
    logic              rsp_err;
    logic              inc_pulse;
    logic [CNT_W-1:0]  inc_count;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output ep_present, init_req, init_inst_id,
        output req_valid, req_blocking, req_method_id, req_inst_id, req_param,
        output rsp_ready,
        input  defined, fatal_err, req_ready,
        input  rsp_valid, rsp_has_retval, rsp_retval, rsp_err,
        input  inc_pulse, inc_count, err_count
    );

    modport slave (
        input  ep_present, init_req, init_inst_id,
        input  req_valid, req_blocking, req_method_id, req_inst_id, req_param,
        input  rsp_ready,
        output defined, fatal_err, req_ready,
        output rsp_valid, rsp_has_retval, rsp_retval, rsp_err,
        output inc_pulse, inc_count, err_count
    );
endinterface

// File: rtl/loopback_smoke_bfm_core.sv
// loopback_smoke_bfm_core: single-outstanding-call loopback interface BFM with one "inc" method
module loopback_smoke_bfm_core #(
    parameter int ID_W   = 64,
    parameter int PRM_W  = 32,
    parameter int INST_W = 16,
    parameter int CNT_W  = 32
) (
    input logic                    clock,
    input logic                    reset,
    loopback_smoke_bfm_core_if.slave bus
);
    typedef enum logic [2:0] {UNDEF, IDLE, EXEC, WAIT_B, RESP, FATAL} state_t;

    state_t            state, state_nx;
    logic [INST_W-1:0] inst_q, rinst_q;
    logic [ID_W-1:0]   mid_q;
    logic              blk_q, err_q;
    logic [CNT_W-1:0]  inc_q, errc_q;
    logic              hit, err_nx, inc_hit, fire_rsp;
    logic              unused_param;

    assign unused_param = ^bus.req_param;

    // call decode: instance match, error verdict and inc side effect, all judged in EXEC
    always_comb begin
        hit      = rinst_q == inst_q;
        err_nx   = !hit || (!blk_q && mid_q != '0);
        inc_hit  = state == EXEC && !blk_q && !err_nx;
        fire_rsp = state == RESP && bus.rsp_ready;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            UNDEF:   if (bus.init_req) state_nx = bus.ep_present ? IDLE : FATAL;
            IDLE:    if (bus.req_valid) state_nx = EXEC;
            EXEC:    state_nx = (hit && blk_q) ? WAIT_B : RESP;
            WAIT_B:  state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = state;
        endcase
    end

    // state register; reset drops any call in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= UNDEF;
        else       state <= state_nx;
    end

    // handle, captured request, error flag and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_q  <= '0;
            rinst_q <= '0;
            mid_q   <= '0;
            blk_q   <= 1'b0;
            err_q   <= 1'b0;
            inc_q   <= '0;
            errc_q  <= '0;
        end else begin
            if (state == UNDEF && bus.init_req && bus.ep_present) inst_q <= bus.init_inst_id;
            if (state == IDLE && bus.req_valid) begin
                rinst_q <= bus.req_inst_id;
                mid_q   <= bus.req_method_id;
                blk_q   <= bus.req_blocking;
            end
            if (state == EXEC) err_q <= err_nx;
            if (inc_hit) inc_q <= inc_q + 1'b1;
            if (fire_rsp && err_q && !(&errc_q)) errc_q <= errc_q + 1'b1;
        end
    end

    assign bus.defined        = state == IDLE || state == EXEC || state == WAIT_B || state == RESP;
    assign bus.fatal_err      = state == FATAL;
    assign bus.req_ready      = state == IDLE;
    assign bus.rsp_valid      = state == RESP;
    assign bus.rsp_err        = state == RESP && err_q;
    assign bus.rsp_has_retval = 1'b0;
    assign bus.rsp_retval     = '0;
    assign bus.inc_pulse      = inc_hit;
    assign bus.inc_count      = inc_q;
    assign bus.err_count      = errc_q;
endmodule

// File: tb/tb_loopback_smoke_bfm_core.sv
// tb_loopback_smoke_bfm_core: directed self-checking bench for the loopback BFM core
module tb_loopback_smoke_bfm_core;
    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat, pulses;
    logic err, seen;
    logic [63:0] all_ones;

    always #5 clock = ~clock;

    loopback_smoke_bfm_core_if #(.CNT_W(CNT_W)) bus ();

    loopback_smoke_bfm_core #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic init(input logic ep, input logic [15:0] inst);
        bus.ep_present   = ep;
        bus.init_req     = 1'b1;
        bus.init_inst_id = inst;
        tick;
        bus.init_req     = 1'b0;
    endtask

    // issue a call and wait for rsp_valid; response is left pending for the caller
    task automatic call(input logic blk, input logic [63:0] id, input logic [15:0] inst,
                        output int l, output int p, output logic e);
        int w = 0;
        bus.req_valid     = 1'b1;
        bus.req_blocking  = blk;
        bus.req_method_id = id;
        bus.req_inst_id   = inst;
        bus.req_param     = 32'hdead_beef;
        while (!bus.req_ready && w < 10) begin
            tick;
            w++;
        end
        l = 0;
        p = 0;
        e = 1'b0;
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        tick;
        bus.req_valid = 1'b0;
        l = 1;
        while (!bus.rsp_valid && l < 10) begin
            p += int'(bus.inc_pulse);
            tick;
            l++;
        end
        p += int'(bus.inc_pulse);
        e = bus.rsp_err;
    endtask

    task automatic finish_rsp;
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        all_ones          = '1;
        bus.ep_present    = 1'b0;
        bus.init_req      = 1'b0;
        bus.init_inst_id  = '0;
        bus.req_valid     = 1'b0;
        bus.req_blocking  = 1'b0;
        bus.req_method_id = '0;
        bus.req_inst_id   = '0;
        bus.req_param     = '0;
        bus.rsp_ready     = 1'b0;
        repeat (2) tick;
        chk("rst_defined", bus.defined, 0);
        chk("rst_fatal", bus.fatal_err, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_inc_count", bus.inc_count, 0);
        chk("rst_err_count", bus.err_count, 0);
        reset = 1'b0;
        tick;
        chk("undef_req_ready", bus.req_ready, 0);

        init(1'b0, 16'd5);
        chk("noep_fatal", bus.fatal_err, 1);
        chk("noep_defined", bus.defined, 0);
        chk("noep_req_ready", bus.req_ready, 0);
        init(1'b1, 16'd5);
        chk("fatal_sticky", bus.fatal_err, 1);
        chk("fatal_req_ready", bus.req_ready, 0);
        chk("fatal_defined", bus.defined, 0);

        #2 reset = 1'b1;
        #1 chk("async_rst_fatal", bus.fatal_err, 0);
        tick;
        reset = 1'b0;
        tick;

        init(1'b1, 16'd5);
        chk("init_defined", bus.defined, 1);
        chk("init_req_ready", bus.req_ready, 1);

        call(1'b0, 64'd0, 16'd5, lat, pulses, err);
        chk("nb_inc_lat", lat, 2);
        chk("nb_inc_pulses", pulses, 1);
        chk("nb_inc_err", err, 0);
        chk("nb_inc_retflag", bus.rsp_has_retval, 0);
        chk("nb_inc_retval", bus.rsp_retval, 0);
        chk("nb_inc_count", bus.inc_count, 1);
        finish_rsp;
        chk("nb_inc_errcnt", bus.err_count, 0);
        chk("nb_inc_idle", bus.req_ready, 1);

        call(1'b0, 64'd7, 16'd5, lat, pulses, err);
        chk("nb_unk_lat", lat, 2);
        chk("nb_unk_err", err, 1);
        chk("nb_unk_pulses", pulses, 0);
        finish_rsp;
        chk("nb_unk_inc", bus.inc_count, 1);
        chk("nb_unk_errcnt", bus.err_count, 1);

        call(1'b1, 64'd0, 16'd5, lat, pulses, err);
        chk("b_lat", lat, 3);
        chk("b_err", err, 0);
        chk("b_pulses", pulses, 0);
        finish_rsp;
        chk("b_inc", bus.inc_count, 1);
        chk("b_errcnt", bus.err_count, 1);

        call(1'b0, 64'd0, 16'd6, lat, pulses, err);
        chk("nb_inst_lat", lat, 2);
        chk("nb_inst_err", err, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_err", bus.rsp_err, 1);
            chk("hold_req_ready", bus.req_ready, 0);
            chk("hold_retval", bus.rsp_retval, 0);
        end
        finish_rsp;
        chk("nb_inst_errcnt", bus.err_count, 2);
        chk("nb_inst_inc", bus.inc_count, 1);

        call(1'b0, all_ones, 16'd5, lat, pulses, err);
        chk("allones_err", err, 1);
        chk("allones_pulses", pulses, 0);
        finish_rsp;
        chk("allones_errcnt", bus.err_count, 3);

        call(1'b1, 64'd0, 16'd9, lat, pulses, err);
        chk("b_inst_lat", lat, 2);
        chk("b_inst_err", err, 1);
        finish_rsp;
        chk("b_inst_errcnt", bus.err_count, 4);

        init(1'b1, 16'd9);
        call(1'b0, 64'd0, 16'd5, lat, pulses, err);
        chk("reinit_ignored_err", err, 0);
        finish_rsp;
        chk("reinit_inc", bus.inc_count, 2);

        for (int i = 0; i < 14; i++) begin
            call(1'b0, 64'd0, 16'd5, lat, pulses, err);
            finish_rsp;
        end
        chk("inc_wrap", bus.inc_count, 0);

        for (int i = 0; i < 13; i++) begin
            call(1'b0, 64'd3, 16'd5, lat, pulses, err);
            finish_rsp;
        end
        chk("err_saturate", bus.err_count, 15);
        chk("sat_inc", bus.inc_count, 0);

        bus.req_valid     = 1'b1;
        bus.req_blocking  = 1'b1;
        bus.req_method_id = 64'd0;
        bus.req_inst_id   = 16'd5;
        chk("wb_accept_ready", bus.req_ready, 1);
        tick;
        bus.req_valid = 1'b0;
        tick;
        chk("wb_no_rsp_yet", bus.rsp_valid, 0);
        #2 reset = 1'b1;
        #1;
        chk("wb_rst_defined", bus.defined, 0);
        chk("wb_rst_rsp_valid", bus.rsp_valid, 0);
        chk("wb_rst_req_ready", bus.req_ready, 0);
        chk("wb_rst_inc", bus.inc_count, 0);
        chk("wb_rst_errcnt", bus.err_count, 0);
        chk("wb_rst_rsp_err", bus.rsp_err, 0);
        tick;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            seen |= bus.rsp_valid;
        end
        chk("wb_no_rsp_after", seen, 0);
        chk("wb_after_defined", bus.defined, 0);
        chk("wb_after_req_ready", bus.req_ready, 0);

        init(1'b1, 16'd5);
        call(1'b0, 64'd0, 16'd5, lat, pulses, err);
        chk("reinit_call_err", err, 0);
        finish_rsp;
        chk("reinit_call_inc", bus.inc_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/loopback_smoke_bfm_core.md
LOOPBACK_SMOKE_BFM_CORE -- requirements
Module: loopback_smoke_bfm_core

Interface
REQ-001 Parameters: ID_W default 64, width of method id; PRM_W default 32, width of parameter/return data; INST_W default 16, width of instance handle; CNT_W default 32, width of counters.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ep_present  input  1  default endpoint available, sampled at init.
REQ-005 init_req  input  1  one-cycle request to define the interface instance.
REQ-006 init_inst_id  input  INST_W  instance handle to register.
REQ-007 defined  output  1  instance registered, calls accepted.
REQ-008 fatal_err  output  1  sticky; init attempted with no endpoint.
REQ-009 req_valid / req_ready  input / output  1 / 1  invocation handshake.
REQ-010 req_blocking  input  1  0 = invoke_nb, 1 = invoke_b.
REQ-011 req_method_id  input  ID_W  method id.
REQ-012 req_inst_id  input  INST_W  target instance handle.
REQ-013 req_param  input  PRM_W  parameter word (ignored by all defined methods).
REQ-014 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-015 rsp_has_retval  output  1  always 0 (null return).
REQ-016 rsp_retval  output  PRM_W  always 0.
REQ-017 rsp_err  output  1  response reports unknown method or wrong instance.
REQ-018 inc_pulse  output  1  one-cycle pulse per executed inc.
REQ-019 inc_count  output  CNT_W  number of executed inc calls, wraps modulo 2^CNT_W.
REQ-020 err_count  output  CNT_W  number of error responses, saturates at all-ones.

Function
REQ-021 FSM states: UNDEF, IDLE, EXEC, WAIT_B, RESP, FATAL.
REQ-022 UNDEF: req_ready=0; init_req with ep_present=1 latches init_inst_id, sets defined=1, goes to IDLE next cycle.
REQ-023 UNDEF: init_req with ep_present=0 sets fatal_err=1, goes to FATAL; FATAL is left only by reset.
REQ-024 init_req outside UNDEF is ignored; the registered handle never changes until reset.
REQ-025 IDLE: req_ready=1; transfer when req_valid&req_ready; the request is captured and the FSM goes to EXEC.
REQ-026 EXEC, non-blocking: method id 0 with matching inst_id -> inc_pulse=1 for exactly this cycle, inc_count+1, rsp_err=0.
REQ-027 EXEC, non-blocking: any other method id -> no inc side effect, rsp_err=1.
REQ-028 EXEC, blocking: no side effect for any id, rsp_err=0, goes to WAIT_B for exactly 1 cycle, then RESP (invoke_b latency 3 cycles from accept to rsp_valid).
REQ-029 EXEC, inst_id mismatch (either kind): no side effect, rsp_err=1, direct to RESP.
REQ-030 Non-blocking accept to rsp_valid latency 2 cycles; rsp_valid asserted in RESP.
REQ-031 RESP: rsp_valid=1; outputs stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE; err_count increments on that transfer if rsp_err=1.
REQ-032 Exactly one outstanding call; req_ready=0 in EXEC, WAIT_B, RESP, FATAL, UNDEF.
REQ-033 Full ID_W bits compared; method id 2^ID_W-1 is unknown, not aliased to 0.
REQ-034 inc_count wraps from all-ones to 0; err_count holds at all-ones.

Reset
REQ-035 Reset asserted asynchronously forces UNDEF; defined, fatal_err, req_ready, rsp_valid, rsp_has_retval, rsp_err, inc_pulse = 0; rsp_retval, inc_count, err_count, latched handle = 0.
REQ-036 Reset mid-call (EXEC/WAIT_B/RESP) discards the call; no response is produced after release.
REQ-037 After reset release, init is required again before calls are accepted.

Verification
REQ-038 Reset, init_req with ep_present=0, inst 5 -> fatal_err=1, defined=0, req_ready stays 0 across later init_req.
REQ-039 Init inst 5, nb call id 0 inst 5 -> inc_pulse one cycle, inc_count=1, rsp_valid 2 cycles after accept, rsp_err=0, rsp_has_retval=0.
REQ-040 Nb call id 7 inst 5 -> rsp_err=1, inc_count unchanged, err_count=1.
REQ-041 Blocking call id 0 inst 5 -> rsp_valid 3 cycles after accept, rsp_err=0, inc_count unchanged.
REQ-042 Nb call id 0 inst 6 -> rsp_err=1; rsp_ready held low 4 cycles -> rsp_valid and outputs held, req_ready=0 throughout.
REQ-043 Reset asserted during WAIT_B -> all outputs zero immediately, no response after release, defined=0.
